// File: rtl/dds_pkg.sv
// Shared types and helpers for the multichannel DDS.
//   cfg_sel_t   : selects tuning word or phase offset on config writes
//   state_t     : round sequencer states
//   DDS_RAM_LAT : read latency of the waveform table (read reg + output reg)
//   qtr_fold()  : maps a phase word to {neg, table address}
package dds_pkg;

   typedef enum logic {CFG_TW = 1'b0, CFG_OFF = 1'b1} cfg_sel_t;
   typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   localparam int unsigned DDS_RAM_LAT = 2;
   localparam int unsigned DDS_PMAX    = 64;

   // Returns {neg, addr} right-aligned: addr in [aw-1:0], neg at bit aw.
   function automatic logic [DDS_PMAX-1:0] qtr_fold(input logic [DDS_PMAX-1:0] phase,
                                                   input int unsigned pw,
                                                   input int unsigned aw);
      logic [DDS_PMAX-1:0] mask;
      logic [DDS_PMAX-1:0] idx;
      logic                neg;
      logic                mir;
      mask = (DDS_PMAX'(1) << aw) - DDS_PMAX'(1);
      idx  = (phase >> (pw - 2 - aw)) & mask;
      neg  = |((phase >> (pw - 1)) & DDS_PMAX'(1));
      mir  = |((phase >> (pw - 2)) & DDS_PMAX'(1));
      return (DDS_PMAX'(neg) << aw) | (mir ? (~idx & mask) : idx);
   endfunction

endpackage

// File: rtl/dds_wfm_bram.sv
// Simple dual-port quarter-wave table: one write port, one registered read
// port followed by an output register (two clocks read latency).
//   clk   : clock
//   wea   : write enable        waddr : write address   din : write data
//   raddr : read address        dout  : read data (registered twice)
// Contents are never reset; a read of the address being written returns old data.
module dds_wfm_bram #(
   parameter int unsigned DEPTH    = 1024,
   parameter int unsigned OW       = 24,
   parameter string       WFM_FILE = "",
   localparam int unsigned AW      = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wea,
   input  logic [AW-1:0] waddr,
   input  logic [OW-1:0] din,
   input  logic [AW-1:0] raddr,
   output logic [OW-1:0] dout
);

   logic [OW-1:0] mem_q [DEPTH];
   logic [OW-1:0] rd_d, rd_q;
   logic [OW-1:0] dout_q;

   always_comb rd_d = mem_q[raddr];

   always_ff @(posedge clk) begin
      if (wea) mem_q[waddr] <= din;
      rd_q   <= rd_d;
      dout_q <= rd_q;
   end

   assign dout = dout_q;

endmodule

// File: rtl/dds_multichannel.sv
// Time-multiplexed N-channel DDS sharing one quarter-wave table.
//   ce/sync           : round start strobe / clear accumulators at next round start
//   cfg_we/sel/ch/data: shadow config writes (tuning word or phase offset)
//   wfm_wea/waddr/din : table write port
//   busy/overrun      : round in progress / sticky ce-while-busy
//   out_valid/out_ch/ampl : channel-tagged samples, 4 clocks after issue
module dds_multichannel
   import dds_pkg::*;
#(
   parameter int unsigned NCH      = 4,
   parameter int unsigned DEPTH    = 1024,
   parameter int unsigned TW       = 24,
   parameter int unsigned PW       = 26,
   parameter int unsigned OW       = 24,
   parameter string       WFM_FILE = "",
   localparam int unsigned AW      = $clog2(DEPTH),
   localparam int unsigned CFW     = $clog2(NCH) + 1,
   localparam int unsigned CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           ce,
   input  logic           sync,
   input  logic           cfg_we,
   input  logic           cfg_sel,
   input  logic [CFW-1:0] cfg_ch,
   input  logic [PW-1:0]  cfg_data,
   input  logic           wfm_wea,
   input  logic [AW-1:0]  wfm_waddr,
   input  logic [OW-1:0]  wfm_din,
   output logic           busy,
   output logic           overrun,
   output logic           out_valid,
   output logic [CW-1:0]  out_ch,
   output logic [OW-1:0]  ampl
);

   localparam int unsigned LL = DDS_RAM_LAT - 1;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           busy_q, busy_d;
   logic           overrun_q, overrun_d;
   logic           sync_pend_q, sync_pend_d;

   logic [TW-1:0]  tw_sh_q  [NCH], tw_sh_d  [NCH];
   logic [PW-1:0]  off_sh_q [NCH], off_sh_d [NCH];
   logic [TW-1:0]  tw_q     [NCH], tw_d     [NCH];
   logic [PW-1:0]  off_q    [NCH], off_d    [NCH];
   logic [PW-1:0]  acc_q    [NCH], acc_d    [NCH];

   logic           s1_vld_q, s1_vld_d;
   logic           s1_neg_q, s1_neg_d;
   logic [CW-1:0]  s1_ch_q, s1_ch_d;
   logic [AW-1:0]  s1_addr_q, s1_addr_d;

   logic [LL:0]    s2_vld_q, s2_vld_d;
   logic [LL:0]    s2_neg_q, s2_neg_d;
   logic [CW-1:0]  s2_ch_q [DDS_RAM_LAT], s2_ch_d [DDS_RAM_LAT];

   logic           out_valid_q, out_valid_d;
   logic [CW-1:0]  out_ch_q, out_ch_d;
   logic [OW-1:0]  ampl_q, ampl_d;

   logic           start_c;
   logic           issue_c;
   logic [PW-1:0]  phase_c;
   logic [OW-1:0]  ram_dout;

   assign start_c = ce && (state_q == ST_IDLE);
   assign issue_c = (state_q == ST_RUN);
   assign phase_c = acc_q[cnt_q] + off_q[cnt_q];

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: one RUN cycle per channel.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (ce) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
         end
         ST_RUN: begin
            if (cnt_q == CW'(NCH - 1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy_d    = (state_d == ST_RUN);
      overrun_d = overrun_q | (ce && (state_q == ST_RUN));
   end

   // Config shadow/commit, accumulators and the read pipeline.
   always_comb begin
      tw_sh_d     = tw_sh_q;
      off_sh_d    = off_sh_q;
      tw_d        = tw_q;
      off_d       = off_q;
      acc_d       = acc_q;
      sync_pend_d = sync_pend_q;

      // Commit reads the pre-write shadow, so a same-cycle write lands next round.
      if (start_c) begin
         tw_d        = tw_sh_q;
         off_d       = off_sh_q;
         sync_pend_d = 1'b0;
         if (sync || sync_pend_q) begin
            for (int i = 0; i < int'(NCH); i++) acc_d[i] = '0;
         end
      end else if (sync) begin
         sync_pend_d = 1'b1;
      end

      if (cfg_we && (cfg_ch < CFW'(NCH))) begin
         if (cfg_sel_t'(cfg_sel) == CFG_OFF) off_sh_d[CW'(cfg_ch)] = cfg_data;
         else                                tw_sh_d[CW'(cfg_ch)]  = cfg_data[TW-1:0];
      end

      if (issue_c) acc_d[cnt_q] = acc_q[cnt_q] + PW'(tw_q[cnt_q]);

      s1_vld_d                = issue_c;
      s1_ch_d                 = cnt_q;
      {s1_neg_d, s1_addr_d}   = (AW + 1)'(qtr_fold(DDS_PMAX'(phase_c), PW, AW));

      // Sideband travels alongside the table read latency.
      s2_vld_d[0] = s1_vld_q;
      s2_neg_d[0] = s1_neg_q;
      s2_ch_d[0]  = s1_ch_q;
      for (int i = 1; i < int'(DDS_RAM_LAT); i++) begin
         s2_vld_d[i] = s2_vld_q[i-1];
         s2_neg_d[i] = s2_neg_q[i-1];
         s2_ch_d[i]  = s2_ch_q[i-1];
      end

      out_valid_d = s2_vld_q[LL];
      out_ch_d    = out_ch_q;
      ampl_d      = ampl_q;
      if (s2_vld_q[LL]) begin
         out_ch_d = s2_ch_q[LL];
         ampl_d   = s2_neg_q[LL] ? (OW'(0) - ram_dout) : ram_dout;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
         sync_pend_q <= 1'b0;
         for (int i = 0; i < int'(NCH); i++) begin
            tw_sh_q[i]  <= '0;
            off_sh_q[i] <= '0;
            tw_q[i]     <= '0;
            off_q[i]    <= '0;
            acc_q[i]    <= '0;
         end
         s1_vld_q  <= 1'b0;
         s1_neg_q  <= 1'b0;
         s1_ch_q   <= '0;
         s1_addr_q <= '0;
         s2_vld_q  <= '0;
         s2_neg_q  <= '0;
         for (int i = 0; i < int'(DDS_RAM_LAT); i++) s2_ch_q[i] <= '0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         ampl_q      <= '0;
      end else begin
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
         sync_pend_q <= sync_pend_d;
         tw_sh_q     <= tw_sh_d;
         off_sh_q    <= off_sh_d;
         tw_q        <= tw_d;
         off_q       <= off_d;
         acc_q       <= acc_d;
         s1_vld_q    <= s1_vld_d;
         s1_neg_q    <= s1_neg_d;
         s1_ch_q     <= s1_ch_d;
         s1_addr_q   <= s1_addr_d;
         s2_vld_q    <= s2_vld_d;
         s2_neg_q    <= s2_neg_d;
         s2_ch_q     <= s2_ch_d;
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
         ampl_q      <= ampl_d;
      end
   end

   dds_wfm_bram #(
      .DEPTH    (DEPTH),
      .OW       (OW),
      .WFM_FILE (WFM_FILE)
   ) u_wfm (
      .clk   (clk),
      .wea   (wfm_wea),
      .waddr (wfm_waddr),
      .din   (wfm_din),
      .raddr (s1_addr_q),
      .dout  (ram_dout)
   );

   assign busy      = busy_q;
   assign overrun   = overrun_q;
   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;
   assign ampl      = ampl_q;

endmodule

// File: tb/tb_dds_multichannel.sv
// Scoreboard bench for dds_multichannel (NCH=4, DEPTH=1024, PW=26, TW=24, OW=24).
module tb_dds_multichannel;

   localparam int NCH = 4;
   localparam int DEPTH = 1024;
   localparam int TW = 24;
   localparam int PW = 26;
   localparam int OW = 24;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ce = 1'b0;
   logic          sync = 1'b0;
   logic          cfg_we = 1'b0;
   logic          cfg_sel = 1'b0;
   logic [2:0]    cfg_ch = '0;
   logic [PW-1:0] cfg_data = '0;
   logic          wfm_wea = 1'b0;
   logic [AW-1:0] wfm_waddr = '0;
   logic [OW-1:0] wfm_din = '0;
   logic          busy, overrun, out_valid;
   logic [1:0]    out_ch;
   logic [OW-1:0] ampl;

   dds_multichannel #(
      .NCH(NCH), .DEPTH(DEPTH), .TW(TW), .PW(PW), .OW(OW), .WFM_FILE("")
   ) dut (
      .clk(clk), .rst_n(rst_n), .ce(ce), .sync(sync),
      .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_ch(cfg_ch), .cfg_data(cfg_data),
      .wfm_wea(wfm_wea), .wfm_waddr(wfm_waddr), .wfm_din(wfm_din),
      .busy(busy), .overrun(overrun), .out_valid(out_valid),
      .out_ch(out_ch), .ampl(ampl)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]    ch;
      logic [OW-1:0] ampl;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          mon_e;
   int            n_vec = 0;
   int            n_bad = 0;
   logic [OW-1:0] tab [DEPTH];
   logic [TW-1:0] m_tw_sh [NCH];
   logic [TW-1:0] m_tw    [NCH];
   logic [PW-1:0] m_off_sh[NCH];
   logic [PW-1:0] m_off   [NCH];
   logic [PW-1:0] m_acc   [NCH];
   bit            m_sync_pend;
   logic [OW-1:0] last_exp;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Independent reference: quadrant decides sign and index direction.
   function automatic logic [OW-1:0] ref_ampl(input logic [PW-1:0] ph);
      int            quad;
      int            idx;
      logic [OW-1:0] v;
      quad = int'(ph[25:24]);
      idx  = int'(ph[23:14]);
      if (quad == 1 || quad == 3) idx = 1023 - idx;
      v = tab[idx];
      return (quad >= 2) ? (24'd0 - v) : v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NCH; k++) begin
         m_tw_sh[k] = '0; m_tw[k] = '0; m_off_sh[k] = '0; m_off[k] = '0; m_acc[k] = '0;
      end
      m_sync_pend = 0;
      last_exp = '0;
      exp_q.delete();
   endtask

   task automatic model_start(input bit s);
      exp_t          e;
      logic [PW-1:0] ph;
      for (int k = 0; k < NCH; k++) begin
         m_tw[k]  = m_tw_sh[k];
         m_off[k] = m_off_sh[k];
      end
      if (s || m_sync_pend) for (int k = 0; k < NCH; k++) m_acc[k] = '0;
      m_sync_pend = 0;
      for (int k = 0; k < NCH; k++) begin
         ph = m_acc[k] + m_off[k];
         e.ch = 2'(k);
         e.ampl = ref_ampl(ph);
         exp_q.push_back(e);
         last_exp = e.ampl;
         m_acc[k] = m_acc[k] + {2'b00, m_tw[k]};
      end
   endtask

   task automatic shadow_write(input int ch, input bit sel, input logic [PW-1:0] d);
      if (ch < NCH) begin
         if (sel) m_off_sh[ch] = d;
         else     m_tw_sh[ch]  = d[TW-1:0];
      end
   endtask

   task automatic cfg_write(input int ch, input bit sel, input logic [PW-1:0] d);
      @(posedge clk); #1;
      cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_sel = sel; cfg_data = d;
      shadow_write(ch, sel, d);
      @(posedge clk); #1;
      cfg_we = 1'b0;
   endtask

   task automatic start_round(input bit s);
      @(posedge clk); #1;
      ce = 1'b1; sync = s;
      model_start(s);
      @(posedge clk); #1;
      ce = 1'b0; sync = 1'b0;
      chk("busy_start", 32'(busy), 32'd1);
   endtask

   task automatic finish_round();
      repeat (NCH) @(posedge clk);
      #1 chk("busy_end", 32'(busy), 32'd0);
      repeat (4) @(posedge clk);
      #1 chk("idle_valid", 32'(out_valid), 32'd0);
      chk("ampl_hold", 32'(ampl), 32'(last_exp));
   endtask

   task automatic round(input bit s);
      start_round(s);
      finish_round();
   endtask

   task automatic check_reset_outputs(input string nm);
      chk({nm, "_busy"}, 32'(busy), 32'd0);
      chk({nm, "_overrun"}, 32'(overrun), 32'd0);
      chk({nm, "_valid"}, 32'(out_valid), 32'd0);
      chk({nm, "_ampl"}, 32'(ampl), 32'd0);
      chk({nm, "_ch"}, 32'(out_ch), 32'd0);
   endtask

   // Monitor: every presented sample must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_sample: got ch %0d ampl %0h, expected none", out_ch, ampl);
         end else begin
            mon_e = exp_q.pop_front();
            chk("out_ch", 32'(out_ch), 32'(mon_e.ch));
            chk("ampl", 32'(ampl), 32'(mon_e.ampl));
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      for (int i = 0; i < DEPTH; i++) tab[i] = 24'(i * 8191 + 1000);

      // Reset behaviour.
      repeat (3) @(posedge clk);
      @(negedge clk) check_reset_outputs("rst_held");
      #1 rst_n = 1'b1;
      @(posedge clk); #1 check_reset_outputs("rst_rel");

      // Table load.
      for (int i = 0; i < DEPTH; i++) begin
         @(posedge clk); #1;
         wfm_wea = 1'b1; wfm_waddr = 10'(i); wfm_din = tab[i];
      end
      @(posedge clk); #1 wfm_wea = 1'b0;

      // Phase offset of half a period negates.
      cfg_write(2, 1'b1, 26'h2000000);
      round(0);

      // Stepping tuning words, including one with sub-LSB phase bits.
      cfg_write(1, 1'b0, 26'h0400000);
      cfg_write(3, 1'b0, 26'h0123457);
      cfg_write(0, 1'b1, 26'h0C00000);
      for (int r = 0; r < 9; r++) round(0);

      // Back-to-back ce: one round only, sticky overrun.
      @(posedge clk); #1 ce = 1'b1;
      model_start(0);
      @(posedge clk); #1;
      @(posedge clk); #1 ce = 1'b0;
      repeat (NCH - 1) @(posedge clk);
      #1 chk("ovr_busy_end", 32'(busy), 32'd0);
      repeat (4) @(posedge clk);
      #1 chk("overrun_set", 32'(overrun), 32'd1);
      round(0);
      chk("overrun_sticky", 32'(overrun), 32'd1);

      // Config written during RUN applies to the next round only.
      start_round(0);
      cfg_write(3, 1'b1, 26'h2000000);
      finish_round();
      round(0);
      cfg_write(4, 1'b1, 26'h1234567);
      cfg_write(5, 1'b0, 26'h0FFFFFF);
      round(0);

      // Write coincident with commit: commit takes the old shadow.
      @(posedge clk); #1;
      ce = 1'b1; cfg_we = 1'b1; cfg_ch = 3'd1; cfg_sel = 1'b1; cfg_data = 26'h1000000;
      model_start(0);
      shadow_write(1, 1'b1, 26'h1000000);
      @(posedge clk); #1 ce = 1'b0; cfg_we = 1'b0;
      finish_round();
      round(0);

      // sync alone in IDLE is held for the next round start.
      @(posedge clk); #1 sync = 1'b1; m_sync_pend = 1;
      @(posedge clk); #1 sync = 1'b0;
      round(0);
      round(0);
      // sync coincident with ce, then sync during RUN.
      round(1);
      start_round(0);
      @(posedge clk); #1 sync = 1'b1; m_sync_pend = 1;
      @(posedge clk); #1 sync = 1'b0;
      finish_round();
      round(0);

      // Reset mid-round flushes the pipeline.
      start_round(0);
      @(posedge clk); #1 rst_n = 1'b0;
      #1 chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_busy", 32'(busy), 32'd0);
      chk("flush_overrun", 32'(overrun), 32'd0);
      model_reset();
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1 chk("post_flush_valid", 32'(out_valid), 32'd0);
      round(0);
      cfg_write(0, 1'b1, 26'h3000000);
      cfg_write(0, 1'b0, 26'h0ABCDE);
      round(0);
      round(0);

      repeat (4) @(posedge clk);
      #1 chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
